// File: rtl/address_issue_wb.sv
// address_issue_wb: A-register file with reservation-based issue to a fixed-latency address add unit.
// Results retire in issue order through a tag pipeline; external writes are refused on reserved registers.
module address_issue_wb #(
   parameter int size   = 32,
   parameter int fu_lat = 6
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            i_instr_valid,
   input  logic [15:0]     i_instr,
   output logic            o_instr_ready,
   output logic [size-1:0] o_Aj,
   output logic [size-1:0] o_Ak,
   output logic [6:0]      o_Instr,
   input  logic [size-1:0] i_Ai,
   input  logic            i_wr_en,
   input  logic [2:0]      i_wr_addr,
   input  logic [size-1:0] i_wr_data,
   input  logic [2:0]      i_rd_addr,
   output logic [size-1:0] o_rd_data,
   output logic            o_illegal,
   output logic            o_wr_err,
   output logic            o_busy
);
   logic [size-1:0] a_q [8];
   logic [size-1:0] a_d [8];
   logic [7:0]      res_q, res_d;
   logic [3:0]      tag_q [fu_lat];
   logic [size-1:0] aj_q, ak_q;
   logic [6:0]      op_q;
   logic            ill_q, werr_q;
   logic [6:0]      op;
   logic [2:0]      ri, rj, rk, wb_i;
   logic            legal, hazard, issue, wb_v, wr_ok;

   assign op            = i_instr[15:9];
   assign ri            = i_instr[8:6];
   assign rj            = i_instr[5:3];
   assign rk            = i_instr[2:0];
   assign legal         = (op == 7'o020) || (op == 7'o021);
   assign hazard        = legal && (res_q[ri] || res_q[rj] || res_q[rk]);
   assign o_instr_ready = !hazard;
   assign issue         = i_instr_valid && legal && !hazard;
   assign wb_v          = tag_q[fu_lat-1][3];
   assign wb_i          = tag_q[fu_lat-1][2:0];
   assign wr_ok         = i_wr_en && !res_q[i_wr_addr];
   assign o_Aj          = aj_q;
   assign o_Ak          = ak_q;
   assign o_Instr       = op_q;
   assign o_illegal     = ill_q;
   assign o_wr_err      = werr_q;
   assign o_busy        = |res_q;
   assign o_rd_data     = a_q[i_rd_addr];

   // A write-back target is always reserved, so it never collides with an accepted external write or a new issue
   always_comb begin
      a_d   = a_q;
      res_d = res_q;
      if (wb_v) begin
         a_d[wb_i]   = i_Ai;
         res_d[wb_i] = 1'b0;
      end
      if (wr_ok) a_d[i_wr_addr] = i_wr_data;
      if (issue) res_d[ri] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int n = 0; n < 8; n++) a_q[n] <= '0;
         for (int n = 0; n < fu_lat; n++) tag_q[n] <= '0;
         res_q  <= '0;
         aj_q   <= '0;
         ak_q   <= '0;
         op_q   <= 7'o000;
         ill_q  <= 1'b0;
         werr_q <= 1'b0;
      end else begin
         a_q      <= a_d;
         res_q    <= res_d;
         tag_q[0] <= {issue, ri};
         for (int n = 1; n < fu_lat; n++) tag_q[n] <= tag_q[n-1];
         op_q     <= issue ? op : 7'o000;
         if (issue) begin
            aj_q <= a_q[rj];
            ak_q <= a_q[rk];
         end
         ill_q  <= i_instr_valid && !legal;
         werr_q <= i_wr_en && res_q[i_wr_addr];
      end
   end
endmodule

// File: tb/tb_address_issue_wb.sv
// tb_address_issue_wb: directed and random stimulus against an in-flight list reference model.
// A monitor pops per-edge expectations and issued operands from queues filled by the driver.
module tb_address_issue_wb;
   localparam int LAT = 6;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        i_instr_valid = 1'b0;
   logic [15:0] i_instr = '0;
   logic        o_instr_ready;
   logic [31:0] o_Aj, o_Ak, i_Ai = '0;
   logic [6:0]  o_Instr;
   logic        i_wr_en = 1'b0;
   logic [2:0]  i_wr_addr = '0, i_rd_addr = '0;
   logic [31:0] i_wr_data = '0, o_rd_data;
   logic        o_illegal, o_wr_err, o_busy;

   address_issue_wb #(.size(32), .fu_lat(LAT)) dut (
      .clk(clk), .rst_n(rst_n), .i_instr_valid(i_instr_valid), .i_instr(i_instr),
      .o_instr_ready(o_instr_ready), .o_Aj(o_Aj), .o_Ak(o_Ak), .o_Instr(o_Instr),
      .i_Ai(i_Ai), .i_wr_en(i_wr_en), .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data),
      .i_rd_addr(i_rd_addr), .o_rd_data(o_rd_data), .o_illegal(o_illegal),
      .o_wr_err(o_wr_err), .o_busy(o_busy)
   );

   always #10 clk = ~clk;

   typedef struct { logic [2:0] idx; int due; logic [31:0] val; } flight_t;
   typedef struct { logic [6:0] op; logic [31:0] aj; logic [31:0] ak; } iss_t;

   logic [31:0] regs [8];
   flight_t     fl[$];
   iss_t        isq[$];
   logic [2:0]  flq[$];
   int          cyc = 0;
   int          total = 0;
   int          bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit rsv(input logic [2:0] r);
      foreach (fl[n]) if (fl[n].idx == r) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [15:0] mk(input logic [6:0] op, input logic [2:0] i, input logic [2:0] j, input logic [2:0] k);
      return {op, i, j, k};
   endfunction

   // one call per clock edge: drive, check combinational outputs, then advance the model across the edge
   task automatic step(input bit v, input logic [15:0] ins, input bit we, input logic [2:0] wa,
                       input logic [31:0] wd, input logic [2:0] ra, output bit acc);
      logic [6:0]  op;
      logic [2:0]  ri, rj, rk;
      logic [31:0] ai, aj, ak;
      bit          legal, haz, iss, ill, werr;
      @(negedge clk);
      op = ins[15:9]; ri = ins[8:6]; rj = ins[5:3]; rk = ins[2:0];
      ai = $urandom;
      if (fl.size() > 0 && fl[0].due == cyc) ai = fl[0].val;
      i_instr_valid = v; i_instr = ins; i_wr_en = we; i_wr_addr = wa; i_wr_data = wd;
      i_Ai = ai; i_rd_addr = ra;
      #1;
      legal = (op == 7'o020) || (op == 7'o021);
      haz   = legal && (rsv(ri) || rsv(rj) || rsv(rk));
      chk("ready", {31'd0, o_instr_ready}, {31'd0, !haz});
      chk("busy", {31'd0, o_busy}, {31'd0, fl.size() != 0});
      chk("rd_data", o_rd_data, regs[ra]);
      iss  = v && legal && !haz;
      ill  = v && !legal;
      werr = we && rsv(wa);
      aj = regs[rj]; ak = regs[rk];
      if (iss) isq.push_back('{op, aj, ak});
      flq.push_back({iss, ill, werr});
      if (fl.size() > 0 && fl[0].due == cyc) begin
         regs[fl[0].idx] = fl[0].val;
         void'(fl.pop_front());
      end
      if (we && !werr) regs[wa] = wd;
      if (iss) fl.push_back('{ri, cyc + LAT, (op == 7'o020) ? aj + ak : aj - ak});
      cyc++;
      acc = iss || ill;
   endtask

   task automatic idle(input int n);
      bit acc;
      for (int c = 0; c < n; c++) step(0, '0, 0, '0, '0, 3'(c), acc);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; i_instr_valid = 1'b0; i_wr_en = 1'b0;
      fl.delete(); isq.delete(); flq.delete();
      for (int r = 0; r < 8; r++) regs[r] = '0;
      #1;
      chk("rst_Aj", o_Aj, 0);
      chk("rst_Ak", o_Ak, 0);
      chk("rst_Instr", {25'd0, o_Instr}, 0);
      chk("rst_flags", {29'd0, o_illegal, o_wr_err, o_busy}, 0);
      chk("rst_ready", {31'd0, o_instr_ready}, 1);
      for (int r = 0; r < 8; r++) begin
         i_rd_addr = 3'(r);
         #1;
         chk("rst_reg", o_rd_data, 0);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic issue_until(input logic [15:0] ins, output int tries);
      bit acc;
      tries = 0;
      do begin
         step(1, ins, 0, '0, '0, 3'($urandom), acc);
         tries++;
      end while (!acc && tries < 30);
      if (!acc) chk("issue_timeout", 0, 1);
   endtask

   initial begin : monitor
      logic [2:0] f;
      iss_t       e;
      forever begin
         @(posedge clk);
         #2;
         if (rst_n && flq.size() > 0) begin
            f = flq.pop_front();
            chk("issued", {31'd0, o_Instr != 7'o000}, {31'd0, f[2]});
            chk("illegal", {31'd0, o_illegal}, {31'd0, f[1]});
            chk("wr_err", {31'd0, o_wr_err}, {31'd0, f[0]});
            if (o_Instr != 7'o000) begin
               if (isq.size() == 0) chk("unexpected_issue", {25'd0, o_Instr}, 0);
               else begin
                  e = isq.pop_front();
                  chk("Instr", {25'd0, o_Instr}, {25'd0, e.op});
                  chk("Aj", o_Aj, e.aj);
                  chk("Ak", o_Ak, e.ak);
               end
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin : driver
      bit acc;
      int tries;
      for (int r = 0; r < 8; r++) regs[r] = '0;
      do_reset();
      step(0, '0, 1, 3'd1, 32'd5, 3'd0, acc);
      step(0, '0, 1, 3'd2, 32'd3, 3'd1, acc);
      issue_until(mk(7'o020, 3'd3, 3'd1, 3'd2), tries);
      chk("first_issue_tries", tries, 1);
      issue_until(mk(7'o021, 3'd4, 3'd3, 3'd1), tries);
      chk("dep_stall_tries", tries, LAT + 1);
      idle(LAT + 2);
      chk("A3", regs[3], 8);
      chk("A4", regs[4], 3);
      step(1, mk(7'o077, 3'd6, 3'd1, 3'd2), 0, '0, '0, 3'd6, acc);
      chk("illegal_accept", {31'd0, acc}, 1);
      idle(8);
      step(1, mk(7'o020, 3'd5, 3'd1, 3'd2), 0, '0, '0, 3'd5, acc);
      idle(1);
      do_reset();
      idle(LAT + 4);
      step(0, '0, 1, 3'd1, 32'd5, 3'd0, acc);
      step(0, '0, 1, 3'd2, 32'd3, 3'd1, acc);
      step(1, mk(7'o020, 3'd5, 3'd1, 3'd2), 0, '0, '0, 3'd5, acc);
      step(0, '0, 1, 3'd5, 32'd9, 3'd5, acc);
      idle(LAT + 2);
      chk("A5_wb", regs[5], 8);
      step(0, '0, 1, 3'd0, 32'd7, 3'd0, acc);
      step(1, mk(7'o020, 3'd1, 3'd0, 3'd0), 0, '0, '0, 3'd1, acc);
      step(1, mk(7'o021, 3'd2, 3'd0, 3'd5), 0, '0, '0, 3'd2, acc);
      step(1, mk(7'o020, 3'd3, 3'd0, 3'd5), 0, '0, '0, 3'd3, acc);
      for (int c = 0; c < LAT + 3; c++) step(0, '0, 0, '0, '0, 3'(1 + c % 3), acc);
      for (int n = 0; n < 400; n++) begin
         int       r;
         logic [6:0] op;
         r  = $urandom_range(0, 9);
         op = (r < 4) ? 7'o020 : (r < 8) ? 7'o021 : 7'($urandom);
         step($urandom_range(0, 3) != 0, mk(op, 3'($urandom), 3'($urandom), 3'($urandom)),
              $urandom_range(0, 3) == 0, 3'($urandom), $urandom, 3'($urandom), acc);
      end
      idle(LAT + 8);
      @(posedge clk);
      #3;
      chk("isq_empty", isq.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
